// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and bus widths.
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

endpackage

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite CSR responder: RW control bank with per-register update pulses
// followed by a read-only status window. One write and one read outstanding.
module axi_lite_csr_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter int unsigned           NUM_CTRL = 8,
    parameter int unsigned           NUM_STAT = 4,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RST = '0
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [DATA_W/8-1:0]      WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,

    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_W-1:0]        RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,

    output logic [NUM_CTRL*32-1:0]   ctrl_q,
    output logic [NUM_CTRL-1:0]      ctrl_wr,
    input  logic [NUM_STAT*32-1:0]   stat_i
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned STRB_W = DATA_W / 8;

    // The register bank and byte-lane logic assume a 32-bit data bus.
    if (DATA_W != AXIL_DATA_W) begin : g_bad_data_w
        $error("axi_lite_csr_slave: DATA_W must be 32");
    end

    // Word-index classification.
    function automatic logic idx_is_ctrl(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(NUM_CTRL);
    endfunction

    function automatic logic idx_is_stat(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_W'(NUM_CTRL)) && (idx < IDX_W'(NUM_CTRL + NUM_STAT));
    endfunction

    // Write-side state
    logic                         aw_held_q, aw_held_d;
    logic [IDX_W-1:0]             aw_idx_q,  aw_idx_d;
    logic                         w_held_q,  w_held_d;
    logic [DATA_W-1:0]            w_data_q,  w_data_d;
    logic [STRB_W-1:0]            w_strb_q,  w_strb_d;
    logic                         awready_q, awready_d;
    logic                         wready_q,  wready_d;
    logic                         bvalid_q,  bvalid_d;
    axi_resp_t                    bresp_q,   bresp_d;
    logic [NUM_CTRL-1:0][31:0]    ctrl_reg_q, ctrl_reg_d;
    logic [NUM_CTRL-1:0]          ctrl_wr_q, ctrl_wr_d;

    // Read-side state
    logic                         arready_q, arready_d;
    logic                         rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]            rdata_q,   rdata_d;
    axi_resp_t                    rresp_q,   rresp_d;

    logic [IDX_W-1:0]             ar_idx;
    logic [DATA_W-1:0]            rd_mux_data;
    axi_resp_t                    rd_mux_resp;

    // Byte offsets within a word carry no meaning for this register map.
    logic                         unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign ar_idx = ARADDR[ADDR_W-1:2];

    // Write path: capture AW/W independently, commit once both are held.
    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ctrl_reg_d = ctrl_reg_q;
        ctrl_wr_d  = '0;

        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end

        if (AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_W-1:2];
        end

        if (WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (idx_is_ctrl(aw_idx_q)) begin
                bresp_d = RESP_OKAY;
                for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                    if (aw_idx_q == IDX_W'(i)) begin
                        ctrl_wr_d[i] = 1'b1;
                        for (int unsigned k = 0; k < STRB_W; k++) begin
                            if (w_strb_q[k]) begin
                                ctrl_reg_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                            end
                        end
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d  && !bvalid_d;
    end

    // Read mux: control bank, then status window, else decode error.
    always_comb begin
        rd_mux_data = '0;
        rd_mux_resp = RESP_SLVERR;
        if (idx_is_ctrl(ar_idx)) begin
            rd_mux_resp = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rd_mux_data = ctrl_reg_q[i];
                end
            end
        end else if (idx_is_stat(ar_idx)) begin
            rd_mux_resp = RESP_OKAY;
            for (int unsigned j = 0; j < NUM_STAT; j++) begin
                if (ar_idx == IDX_W'(NUM_CTRL + j)) begin
                    rd_mux_data = stat_i[32*j +: 32];
                end
            end
        end
    end

    // Read path: sample on AR handshake, hold until R handshake.
    always_comb begin
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;

        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end

        if (ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux_data;
            rresp_d  = rd_mux_resp;
        end

        arready_d = !rvalid_d;
    end

    // State registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            ctrl_reg_q <= CTRL_RST;
            ctrl_wr_q  <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ctrl_reg_q <= ctrl_reg_d;
            ctrl_wr_q  <= ctrl_wr_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign ctrl_q  = ctrl_reg_q;
    assign ctrl_wr = ctrl_wr_q;

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Directed bench for axi_lite_csr_slave: vector table plus handshake corner sequences.
module tb_axi_lite_csr_slave;

    localparam int unsigned NUM_CTRL = 8;
    localparam int unsigned NUM_STAT = 4;
    localparam logic [NUM_CTRL*32-1:0] CTRL_RST = {224'h0, 32'h0000_0001};
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [31:0]                AWADDR;
    logic                       AWVALID;
    logic                       AWREADY;
    logic [31:0]                WDATA;
    logic [3:0]                 WSTRB;
    logic                       WVALID;
    logic                       WREADY;
    logic [1:0]                 BRESP;
    logic                       BVALID;
    logic                       BREADY;
    logic [31:0]                ARADDR;
    logic                       ARVALID;
    logic                       ARREADY;
    logic [31:0]                RDATA;
    logic [1:0]                 RRESP;
    logic                       RVALID;
    logic                       RREADY;
    logic [NUM_CTRL*32-1:0]     ctrl_q;
    logic [NUM_CTRL-1:0]        ctrl_wr;
    logic [NUM_STAT*32-1:0]     stat_i;

    int n_tests = 0;
    int n_fail  = 0;

    int pulse_cnt [NUM_CTRL];
    int long_pulses;
    logic [NUM_CTRL-1:0] prev_wr;

    always #5 clk = ~clk;

    axi_lite_csr_slave #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_CTRL (NUM_CTRL),
        .NUM_STAT (NUM_STAT),
        .CTRL_RST (CTRL_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .ctrl_q  (ctrl_q),
        .ctrl_wr (ctrl_wr),
        .stat_i  (stat_i)
    );

    // Count update pulses per register and any pulse lasting more than one cycle.
    initial begin
        for (int i = 0; i < NUM_CTRL; i++) pulse_cnt[i] = 0;
        long_pulses = 0;
        prev_wr = '0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (ctrl_wr[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
            end
            if ((ctrl_wr & prev_wr) != '0) long_pulses <= long_pulses + 1;
        end
        prev_wr <= ctrl_wr;
    end

    function automatic logic [31:0] get_ctrl(input int i);
        return ctrl_q[32*i +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with AW and W presented together and BREADY held high.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        logic aw_f, w_f;
        resp = 2'bxx;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int c = 0; c < 20 && (AWVALID || WVALID); c++) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            tick();
            if (aw_f) AWVALID = 1'b0;
            if (w_f)  WVALID  = 1'b0;
        end
        chk("write_addr_data_accepted", 32'(AWVALID || WVALID), 32'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int c = 0; c < 20 && !BVALID; c++) tick();
        chk("write_bvalid_seen", 32'(BVALID), 32'd1);
        resp = BRESP;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_f;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        for (int c = 0; c < 20 && ARVALID; c++) begin
            ar_f = ARREADY;
            tick();
            if (ar_f) ARVALID = 1'b0;
        end
        chk("read_addr_accepted", 32'(ARVALID), 32'd0);
        ARVALID = 1'b0;
        for (int c = 0; c < 20 && !RVALID; c++) tick();
        chk("read_rvalid_seen", 32'(RVALID), 32'd1);
        d = RDATA;
        resp = RRESP;
        tick();
        RREADY = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.resp = resp; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] exp_ctrl [NUM_CTRL];

        vecs[0]  = mk(1, 32'h04, 32'hDEADBEEF, 4'hF, OKAY,   32'h0);
        vecs[1]  = mk(0, 32'h04, 32'h0,        4'h0, OKAY,   32'hDEADBEEF);
        vecs[2]  = mk(0, 32'h00, 32'h0,        4'h0, OKAY,   32'h00000001);
        vecs[3]  = mk(1, 32'h00, 32'hAABBCCDD, 4'h5, OKAY,   32'h0);
        vecs[4]  = mk(0, 32'h00, 32'h0,        4'h0, OKAY,   32'h00BB00DD);
        vecs[5]  = mk(0, 32'h20, 32'h0,        4'h0, OKAY,   32'h12345678);
        vecs[6]  = mk(1, 32'h20, 32'hFFFFFFFF, 4'hF, SLVERR, 32'h0);
        vecs[7]  = mk(0, 32'h20, 32'h0,        4'h0, OKAY,   32'h12345678);
        vecs[8]  = mk(0, 32'h40, 32'h0,        4'h0, SLVERR, 32'h0);
        vecs[9]  = mk(1, 32'h40, 32'hFFFFFFFF, 4'hF, SLVERR, 32'h0);
        vecs[10] = mk(0, 32'h1C, 32'h0,        4'h0, OKAY,   32'h0);
        vecs[11] = mk(1, 32'h1F, 32'h55667788, 4'hF, OKAY,   32'h0);
        vecs[12] = mk(0, 32'h1C, 32'h0,        4'h0, OKAY,   32'h55667788);
        vecs[13] = mk(1, 32'h08, 32'hFFFFFFFF, 4'h0, OKAY,   32'h0);
        vecs[14] = mk(0, 32'h08, 32'h0,        4'h0, OKAY,   32'h0);
        vecs[15] = mk(0, 32'h2C, 32'h0,        4'h0, OKAY,   32'hCAFEF00D);
        vecs[16] = mk(0, 32'h30, 32'h0,        4'h0, SLVERR, 32'h0);
        vecs[17] = mk(0, 32'h04, 32'h0,        4'h0, OKAY,   32'hDEADBEEF);

        exp_ctrl = '{32'h00BB00DD, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h55667788};

        stat_i  = {32'hCAFEF00D, 32'h0, 32'h0, 32'h12345678};
        AWADDR  = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR  = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_wready",  32'(WREADY),  32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_bvalid",  32'(BVALID),  32'd0);
        chk("rst_rvalid",  32'(RVALID),  32'd0);
        chk("rst_rdata",   RDATA,        32'd0);
        chk("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        chk("rst_ctrl0",   get_ctrl(0),  32'h00000001);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

        // Vector table
        for (int v = 0; v < 18; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp);
                chk($sformatf("vec%0d_bresp", v), 32'(resp), 32'(vecs[v].resp));
            end else begin
                do_read(vecs[v].addr, rd, resp);
                chk($sformatf("vec%0d_rresp", v), 32'(resp), 32'(vecs[v].resp));
                chk($sformatf("vec%0d_rdata", v), rd, vecs[v].rdata);
            end
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            chk($sformatf("ctrl_q%0d_after_table", i), get_ctrl(i), exp_ctrl[i]);
            chk($sformatf("ctrl_wr%0d_pulses", i), 32'(pulse_cnt[i]),
                (i == 0 || i == 1 || i == 2 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("ctrl_wr_single_cycle", 32'(long_pulses), 32'd0);

        // W three cycles ahead of AW
        AWADDR = 32'h0C; WDATA = 32'h11111111; WSTRB = 4'hF; BREADY = 1'b0;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("wfirst_wready_low",  32'(WREADY),  32'd0);
        chk("wfirst_awready_hi",  32'(AWREADY), 32'd1);
        tick(); tick();
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("wfirst_no_b_yet", 32'(BVALID), 32'd0);
        tick();
        chk("wfirst_bvalid", 32'(BVALID), 32'd1);
        chk("wfirst_bresp",  32'(BRESP),  32'(OKAY));
        chk("wfirst_ctrl3",  get_ctrl(3), 32'h11111111);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("wfirst_b_done", {29'd0, BVALID, AWREADY, WREADY}, 32'd3);

        // AW two cycles ahead of W
        AWADDR = 32'h10; WDATA = 32'h22222222; WSTRB = 4'hF;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("awfirst_awready_low", 32'(AWREADY), 32'd0);
        tick();
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("awfirst_no_b_yet", 32'(BVALID), 32'd0);
        tick();
        chk("awfirst_bvalid", 32'(BVALID), 32'd1);
        chk("awfirst_ctrl4",  get_ctrl(4), 32'h22222222);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;

        // Back-pressured B blocks a second write
        AWADDR = 32'h14; WDATA = 32'h33333333; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("bp_first_bvalid", 32'(BVALID), 32'd1);
        AWADDR = 32'h18; WDATA = 32'h44444444;
        AWVALID = 1'b1; WVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_stall%0d_awready", c), 32'(AWREADY), 32'd0);
            chk($sformatf("bp_stall%0d_bvalid", c),  32'(BVALID),  32'd1);
            tick();
        end
        chk("bp_ctrl6_untouched", get_ctrl(6), 32'h0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bp_after_b_awready", 32'(AWREADY), 32'd1);
        chk("bp_after_b_bvalid",  32'(BVALID),  32'd0);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("bp_second_no_b_yet", 32'(BVALID), 32'd0);
        tick();
        chk("bp_second_bvalid", 32'(BVALID), 32'd1);
        chk("bp_ctrl6",         get_ctrl(6), 32'h44444444);
        chk("bp_ctrl5",         get_ctrl(5), 32'h33333333);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;

        // Read sampling a register on its commit edge sees the old value
        AWADDR = 32'h14; WDATA = 32'h99999999; WSTRB = 4'hF; BREADY = 1'b1;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h14; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        chk("race_rvalid", 32'(RVALID), 32'd1);
        chk("race_rdata",  RDATA,       32'h33333333);
        chk("race_bvalid", 32'(BVALID), 32'd1);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        do_read(32'h14, rd, resp);
        chk("race_readback", rd, 32'h99999999);

        // Reset while a write response is pending
        AWADDR = 32'h08; WDATA = 32'h77777777; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("rstmid_bvalid_before", 32'(BVALID), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_bvalid_async", 32'(BVALID), 32'd0);
        chk("rstmid_ctrl0",        get_ctrl(0), 32'h00000001);
        chk("rstmid_ctrl2",        get_ctrl(2), 32'h0);
        chk("rstmid_ctrl6",        get_ctrl(6), 32'h0);
        tick();
        rst = 1'b0;
        chk("rstmid_ready_low", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick();
        chk("rstmid_ready_high", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        chk("rstmid_no_bvalid",  32'(BVALID), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
